// File: rtl/pmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_responder_pkg
//  Description : LC-3b shared types for the line-granular pmem interface:
//                word/line types, line offset width and the responder states.
//  Revision    : 1.0  initial release
// ============================================================================
package pmem_responder_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;

    // A line is 16 bytes, so the low four address bits select a byte in it.
    localparam int LC3B_LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lc3b_pmem_state;

endpackage : pmem_responder_pkg
`default_nettype wire

// File: rtl/pmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_if
//  Description : Cache-to-physical-memory line bus (one 128-bit line per op).
//  Revision    : 1.0  initial release
// ============================================================================
interface pmem_if;
    import pmem_responder_pkg::*;

    logic      pmem_read;
    logic      pmem_write;
    lc3b_word  pmem_address;
    lc3b_data  pmem_wdata;
    lc3b_data  pmem_rdata;
    logic      pmem_resp;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp
    );

endinterface : pmem_if
`default_nettype wire

// File: rtl/pmem_responder_line_store.sv
`default_nettype none
// ============================================================================
//  Module      : line_store
//  Description : Line-wide backing store, combinational read, synchronous
//                write. Contents are deliberately not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module line_store
    import pmem_responder_pkg::*;
#(
    parameter int LINE_IDX_BITS = 6
) (
    input  wire logic                     clk,
    input  wire logic                     write,
    input  wire logic [LINE_IDX_BITS-1:0] index,
    input  wire lc3b_data                 datain,
    output lc3b_data                      dataout
);

    localparam int c_DEPTH = 2 ** LINE_IDX_BITS;

    lc3b_data r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (write) begin
            r_mem[index] <= datain;
        end
    end

    assign dataout = r_mem[index];

endmodule : line_store
`default_nettype wire

// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_responder
//  Description : Fixed-latency physical-memory responder for the LC-3b cache.
//                Optional macro PMEM_STATS_EN adds saturating read/write
//                completion counters (read_count, write_count).
//  Revision    : 1.0  initial release
// ============================================================================
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int LINE_IDX_BITS = 6,
    parameter int LATENCY       = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pmem_if.slave       pmem
`ifdef PMEM_STATS_EN
    ,
    output logic [15:0] read_count,
    output logic [15:0] write_count
`endif
);

    localparam int       c_IDX_LO     = LC3B_LINE_OFFSET_BITS;
    localparam int       c_IDX_HI     = LC3B_LINE_OFFSET_BITS + LINE_IDX_BITS - 1;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    lc3b_pmem_state           r_state;
    logic [3:0]               r_count;
    logic                     r_is_write;
    logic [LINE_IDX_BITS-1:0] r_index;
    lc3b_data                 r_wdata;
    logic                     r_resp;
    lc3b_data                 r_rdata;

    logic [LINE_IDX_BITS-1:0] w_req_index;
    logic [LINE_IDX_BITS-1:0] w_store_index;
    logic                     w_store_write;
    lc3b_data                 w_store_rdata;
    logic                     w_req;
    logic                     w_unused_addr_bits;

    assign w_req       = pmem.pmem_read | pmem.pmem_write;
    assign w_req_index = pmem.pmem_address[c_IDX_HI:c_IDX_LO];
    assign w_unused_addr_bits = ^{pmem.pmem_address[15:c_IDX_HI+1],
                                  pmem.pmem_address[c_IDX_LO-1:0]};

    // With LATENCY=1 the read data is captured on the acceptance edge, before
    // the index register holds the new request, so look up the live index.
    assign w_store_index = (r_state == IDLE) ? w_req_index : r_index;
    assign w_store_write = (r_state == RESP) && r_is_write;

    line_store #(
        .LINE_IDX_BITS (LINE_IDX_BITS)
    ) u_line_store (
        .clk     (clk),
        .write   (w_store_write),
        .index   (w_store_index),
        .datain  (r_wdata),
        .dataout (w_store_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_is_write <= 1'b0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_resp     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp <= 1'b0;
                    if (w_req) begin
                        // Write wins when both strobes are raised together.
                        r_is_write <= pmem.pmem_write;
                        r_index    <= w_req_index;
                        r_wdata    <= pmem.pmem_wdata;
                        r_count    <= c_CNT_LOAD;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                            if (!pmem.pmem_write) begin
                                r_rdata <= w_store_rdata;
                            end
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (r_count == 4'd0) begin
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        if (!r_is_write) begin
                            r_rdata <= w_store_rdata;
                        end
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_resp  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_resp  <= 1'b0;
                end
            endcase
        end
    end

    assign pmem.pmem_resp  = r_resp;
    assign pmem.pmem_rdata = r_rdata;

`ifdef PMEM_STATS_EN
    logic [15:0] r_read_count;
    logic [15:0] r_write_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_count  <= '0;
            r_write_count <= '0;
        end else if (r_state == RESP) begin
            if (r_is_write) begin
                if (r_write_count != 16'hFFFF) begin
                    r_write_count <= r_write_count + 16'd1;
                end
            end else if (r_read_count != 16'hFFFF) begin
                r_read_count <= r_read_count + 16'd1;
            end
        end
    end

    assign read_count  = r_read_count;
    assign write_count = r_write_count;
`endif

endmodule : pmem_responder
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmem_responder
//  Description : Scoreboard bench for pmem_responder: a driver queues expected
//                responses, an independent monitor checks each pmem_resp.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pmem_responder;
    import pmem_responder_pkg::*;

    localparam int c_LATENCY  = 4;
    localparam int c_IDX_BITS = 6;

    typedef struct {
        bit       is_write;
        lc3b_data rdata;
        int       resp_cyc;
        string    name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t     exp_q[$];
    lc3b_data model [int];
    lc3b_data last_rdata = '0;

    pmem_if bus ();

`ifdef PMEM_STATS_EN
    logic [15:0] read_count;
    logic [15:0] write_count;
`endif

    pmem_responder #(
        .LINE_IDX_BITS (c_IDX_BITS),
        .LATENCY       (c_LATENCY)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pmem (bus.slave)
`ifdef PMEM_STATS_EN
        ,
        .read_count  (read_count),
        .write_count (write_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check128(input string name, input lc3b_data got, input lc3b_data want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every pmem_resp must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.pmem_resp === 1'b1) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got resp=1 at cycle %0d want no response", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.resp_cyc) begin
                    errors++;
                    $display("FAIL %s latency: got resp at cycle %0d want cycle %0d", e.name, cyc, e.resp_cyc);
                end
                check128({e.name, " rdata"}, bus.pmem_rdata, e.rdata);
            end
        end
    end

    task automatic do_op(input string name, input bit rd, input bit wr,
                         input lc3b_word addr, input lc3b_data wd,
                         input bit chg, input lc3b_word addr2, input lc3b_data wd2);
        exp_t e;
        int   idx;
        int   waited;
        @(negedge clk);
        bus.pmem_read    = rd;
        bus.pmem_write   = wr;
        bus.pmem_address = addr;
        bus.pmem_wdata   = wd;
        idx        = int'(addr[c_IDX_BITS+3:4]);
        e.name     = name;
        e.is_write = wr;
        e.resp_cyc = cyc + 1 + c_LATENCY;
        if (wr) begin
            model[idx] = wd;
            e.rdata    = last_rdata;
        end else begin
            e.rdata    = model[idx];
            last_rdata = model[idx];
        end
        exp_q.push_back(e);
        waited = 0;
        if (chg) begin
            @(negedge clk);
            @(negedge clk);
            bus.pmem_address = addr2;
            bus.pmem_wdata   = wd2;
            waited = 2;
        end
        while (bus.pmem_resp !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        if (bus.pmem_resp !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no resp in %0d cycles want resp", name, waited);
            void'(exp_q.pop_back());
        end
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
    endtask

    task automatic reset_now(input string name);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check128({name, " resp"}, 128'(bus.pmem_resp), 128'd0);
        check128({name, " rdata"}, bus.pmem_rdata, 128'd0);
        last_rdata = '0;
        @(negedge clk);
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        rst = 1'b0;
    endtask

    localparam lc3b_data c_L1 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
    localparam lc3b_data c_L2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam lc3b_data c_L3 = 128'hAAAA5555_AAAA5555_AAAA5555_AAAA5555;
    localparam lc3b_data c_L4 = 128'h11112222_33334444_55556666_77778888;
    localparam lc3b_data c_L5 = 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00;
    localparam lc3b_data c_L6 = 128'h600DF00D_600DF00D_600DF00D_600DF00D;
    localparam lc3b_data c_L7 = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
    localparam lc3b_data c_ONES = {128{1'b1}};

    initial begin
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        #1 rst = 1'b1;
        #1;
        check128("por resp", 128'(bus.pmem_resp), 128'd0);
        check128("por rdata", bus.pmem_rdata, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef PMEM_STATS_EN
        check128("write_count after reset", 128'(write_count), 128'd0);
`endif

        do_op("wr_1234", 1'b0, 1'b1, 16'h1234, c_L1, 1'b0, '0, '0);
`ifdef PMEM_STATS_EN
        @(negedge clk);
        check128("write_count after write", 128'(write_count), 128'd1);
`endif
        do_op("rd_1238", 1'b1, 1'b0, 16'h1238, '0, 1'b0, '0, '0);
        reset_now("midcycle_reset");

        do_op("wr_0010", 1'b0, 1'b1, 16'h0010, c_L2, 1'b0, '0, '0);
        do_op("rd_001F", 1'b1, 1'b0, 16'h001F, '0, 1'b0, '0, '0);
        do_op("rd_0410_wrap", 1'b1, 1'b0, 16'h0410, '0, 1'b0, '0, '0);

        do_op("wr_0050", 1'b0, 1'b1, 16'h0050, c_L5, 1'b0, '0, '0);
        do_op("wr_0040_chg", 1'b0, 1'b1, 16'h0040, c_L3, 1'b1, 16'h0050, c_L4);
        do_op("rd_0040", 1'b1, 1'b0, 16'h0040, '0, 1'b0, '0, '0);
        do_op("rd_0050", 1'b1, 1'b0, 16'h0050, '0, 1'b0, '0, '0);
        do_op("rd_0040_chg", 1'b1, 1'b0, 16'h0040, '0, 1'b1, 16'h0050, '0);

        do_op("rdwr_0020", 1'b1, 1'b1, 16'h0020, c_ONES, 1'b0, '0, '0);
        do_op("rd_0020", 1'b1, 1'b0, 16'h0020, '0, 1'b0, '0, '0);

        do_op("wr_0030", 1'b0, 1'b1, 16'h0030, c_L6, 1'b0, '0, '0);
        // Abort a write to 0x0030 while the responder is still counting down.
        @(negedge clk);
        bus.pmem_write   = 1'b1;
        bus.pmem_address = 16'h0030;
        bus.pmem_wdata   = c_L7;
        @(negedge clk);
        reset_now("abort_reset");
`ifdef PMEM_STATS_EN
        check128("write_count after abort", 128'(write_count), 128'd0);
`endif
        repeat (8) @(negedge clk);
        do_op("rd_0030_after_abort", 1'b1, 1'b0, 16'h0030, '0, 1'b0, '0, '0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d outstanding responses want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pmem_responder
`default_nettype wire
